// File: rtl/axi_write_adapter_pkg.sv
// rtl/axi_write_adapter_pkg.sv - shared write-channel state encodings and AXI constants
package axi_write_adapter_pkg;

  typedef enum logic [1:0] {
    W_FREE = 2'd0,
    W_SEND = 2'd1,
    W_RESP = 2'd2,
    W_DONE = 2'd3
  } w_state_t;

  localparam logic [3:0] LEN_SINGLE = 4'd0;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [2:0] PROT_DATA  = 3'b001;

  // bresp[1] set means SLVERR or DECERR; bresp[0] separates DECERR/EXOKAY.
  localparam int RESP_ERR_BIT = 1;
  localparam int RESP_DEC_BIT = 0;

  // kseg0 (100) and kseg1 (101) both alias physical memory from address 0.
  function automatic logic [31:0] kseg_strip(input logic [31:0] vaddr);
    if (vaddr[31:30] == 2'b10) begin
      kseg_strip = {3'b000, vaddr[28:0]};
    end else begin
      kseg_strip = vaddr;
    end
  endfunction

endpackage

// File: rtl/axi_addr_map.sv
// rtl/axi_addr_map.sv - combinational kseg address mapper shared by read and write adapters
module axi_addr_map
  import axi_write_adapter_pkg::*;
#(
  parameter bit EN = 1'b1
) (
  input  logic [31:0] vaddr,
  output logic [31:0] paddr
);

  assign paddr = EN ? kseg_strip(vaddr) : vaddr;

endmodule

// File: rtl/axi_write_adapter.sv
// rtl/axi_write_adapter.sv - single-beat AXI3 write master serving MEM-stage stores
module axi_write_adapter
  import axi_write_adapter_pkg::*;
#(
  parameter logic [3:0] AXI_ID      = 4'b0001,
  parameter bit         ADDR_MAP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic [3:0]  mem_sel,
  output logic        mem_write_done,
  output logic        mem_write_err,
  output logic        write_busy
);

  w_state_t    state;
  logic        aw_done;
  logic        w_done;
  logic [31:0] mapped_addr;
  logic        aw_fire;
  logic        w_fire;
  logic        unused_bits;

  axi_addr_map #(
    .EN(ADDR_MAP_EN)
  ) u_addr_map (
    .vaddr(mem_addr),
    .paddr(mapped_addr)
  );

  // Fixed attributes: one word-sized beat per transaction.
  assign awid    = AXI_ID;
  assign wid     = AXI_ID;
  assign awlen   = LEN_SINGLE;
  assign awsize  = SIZE_WORD;
  assign awburst = BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = PROT_DATA;
  assign wlast   = 1'b1;

  assign aw_fire    = awvalid && awready;
  assign w_fire     = wvalid && wready;
  assign bready     = (state == W_RESP);
  assign write_busy = (state != W_FREE);

  // Response id and the low response bit carry no information for a single outstanding store.
  assign unused_bits = ^{bid, bresp[RESP_DEC_BIT]};

  // Store sequencer: accept, run AW/W independently, wait for B, pulse done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= W_FREE;
      awvalid        <= 1'b0;
      wvalid         <= 1'b0;
      awaddr         <= 32'd0;
      wdata          <= 32'd0;
      wstrb          <= 4'd0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      mem_write_done <= 1'b0;
      mem_write_err  <= 1'b0;
    end else begin
      mem_write_done <= 1'b0;
      case (state)
        W_FREE: begin
          if (mem_we) begin
            if (mem_sel != 4'b0000) begin
              awaddr  <= mapped_addr;
              wdata   <= mem_data;
              wstrb   <= mem_sel;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
              state   <= W_SEND;
            end else begin
              // Nothing to write: complete without touching the bus.
              mem_write_done <= 1'b1;
              state          <= W_DONE;
            end
          end
        end
        W_SEND: begin
          if (aw_fire) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_fire) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            state <= W_RESP;
          end
        end
        W_RESP: begin
          if (bvalid) begin
            mem_write_err  <= bresp[RESP_ERR_BIT];
            mem_write_done <= 1'b1;
            state          <= W_DONE;
          end
        end
        W_DONE: begin
          // The request is still held here; ignore it so it is not issued twice.
          state <= W_FREE;
        end
        default: begin
          state <= W_FREE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_write_adapter.sv
// tb/tb_axi_write_adapter.sv - scoreboard bench for the AXI write adapter
module tb_axi_write_adapter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [3:0]  bid = 4'b0001;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_data = 32'd0;
  logic [3:0]  mem_sel = 4'd0;
  logic        mem_write_done;
  logic        mem_write_err;
  logic        write_busy;

  int errors = 0;
  int checks = 0;

  int       aw_lat = 0;
  int       w_lat = 0;
  bit       b_early = 1'b0;
  logic [1:0] resp_val = 2'b00;
  int       aw_cnt = 0;
  int       w_cnt = 0;
  int       b_pend = 0;
  int       b_count = 0;
  int       done_count = 0;

  logic [31:0] aw_obs[$];
  logic [35:0] w_obs[$];
  logic [67:0] exp_q[$];

  logic        tr_busy[64];
  logic        tr_awv[64];
  logic        tr_wv[64];
  logic        tr_br[64];
  logic        tr_done[64];
  logic        tr_err[64];
  logic [31:0] tr_awaddr[64];
  int          done_cycle;

  axi_write_adapter #(
    .AXI_ID(4'b0001),
    .ADDR_MAP_EN(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_sel(mem_sel),
    .mem_write_done(mem_write_done), .mem_write_err(mem_write_err), .write_busy(write_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] map_addr(input logic [31:0] a);
    if (a[31:29] == 3'b100 || a[31:29] == 3'b101) return {3'b000, a[28:0]};
    return a;
  endfunction

  // Slave model: readies after a programmable number of valid cycles; B after the W beat.
  always @(negedge clk) begin
    awready = awvalid && (aw_cnt >= aw_lat);
    aw_cnt  = awvalid ? aw_cnt + 1 : 0;
    wready  = wvalid && (w_cnt >= w_lat);
    w_cnt   = wvalid ? w_cnt + 1 : 0;
    bvalid  = b_early || (b_pend > 0);
    bresp   = bvalid ? resp_val : 2'b00;
  end

  // Bus monitor feeding the observed side of the scoreboard.
  always @(posedge clk) begin
    if (awvalid && awready) aw_obs.push_back(awaddr);
    if (wvalid && wready) begin
      w_obs.push_back({wdata, wstrb});
      b_pend++;
    end
    if (bvalid && bready) begin
      b_count++;
      b_pend--;
    end
    if (mem_write_done) done_count++;
  end

  task automatic sb_take(output logic [67:0] got, output logic [67:0] exp, output bit ok);
    ok  = (aw_obs.size() > 0) && (w_obs.size() > 0) && (exp_q.size() > 0);
    got = 'x;
    exp = '0;
    if (ok) begin
      got = {aw_obs.pop_front(), w_obs.pop_front()};
      exp = exp_q.pop_front();
    end
  endtask

  task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 64; i++) begin
      tr_busy[i] = 0; tr_awv[i] = 0; tr_wv[i] = 0; tr_br[i] = 0;
      tr_done[i] = 0; tr_err[i] = 0; tr_awaddr[i] = 0;
    end
    done_cycle = -1;
    @(negedge clk);
    mem_addr = a; mem_data = d; mem_sel = s; mem_we = 1'b1;
    if (s != 4'd0) exp_q.push_back({map_addr(a), d, s});
    for (int c = 1; c < 60; c++) begin
      @(negedge clk);
      tr_busy[c] = write_busy; tr_awv[c] = awvalid; tr_wv[c] = wvalid; tr_br[c] = bready;
      tr_done[c] = mem_write_done; tr_err[c] = mem_write_err; tr_awaddr[c] = awaddr;
      if (mem_write_done && done_cycle < 0) done_cycle = c;
      if (done_cycle >= 0 && c == done_cycle + 1) mem_we = 1'b0;
      if (done_cycle >= 0 && c == done_cycle + 2) break;
    end
    if (done_cycle < 0) begin
      mem_we = 1'b0;
      checks++; errors++;
      $display("FAIL store_timeout: no done for addr %h", a);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({awvalid, wvalid, mem_write_done, mem_write_err, write_busy, bready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {awvalid, wvalid, mem_write_done, mem_write_err, write_busy, bready});
    end
    checks++;
    if ({awaddr, wdata, wstrb} !== 68'd0) begin
      errors++;
      $display("FAIL reset_payload: got %h/%h/%h want 0", awaddr, wdata, wstrb);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({awid, awlen, awsize, awburst, awlock, awcache, awprot, wid, wlast} !==
        {4'b0001, 4'd0, 3'b010, 2'b01, 2'b00, 4'd0, 3'b001, 4'b0001, 1'b1}) begin
      errors++;
      $display("FAIL fixed_attrs: got %h", {awid, awlen, awsize, awburst, awlock, awcache, awprot, wid, wlast});
    end
    checks++;
    if (write_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %b want 0", write_busy);
    end
  endtask

  task automatic test_zero_wait();
    logic [67:0] got, exp;
    bit ok;
    int d0;
    d0 = done_count;
    run_store(32'h8000_1000, 32'hDEAD_BEEF, 4'hF);
    checks++;
    if (done_cycle != 3) begin
      errors++;
      $display("FAIL zw_latency: got done cycle %0d want 3", done_cycle);
    end
    checks++;
    if ({tr_busy[1], tr_busy[2], tr_busy[3], tr_busy[4]} !== 4'b1110) begin
      errors++;
      $display("FAIL zw_busy: got %b want 1110", {tr_busy[1], tr_busy[2], tr_busy[3], tr_busy[4]});
    end
    checks++;
    if ({tr_done[2], tr_done[3], tr_done[4]} !== 3'b010 || done_count - d0 != 1) begin
      errors++;
      $display("FAIL zw_done_pulse: got %b count %0d want 010 count 1",
               {tr_done[2], tr_done[3], tr_done[4]}, done_count - d0);
    end
    sb_take(got, exp, ok);
    checks++;
    if (!ok || got !== exp || exp !== {32'h0000_1000, 32'hDEAD_BEEF, 4'hF}) begin
      errors++;
      $display("FAIL zw_beat: got %h want %h", got, {32'h0000_1000, 32'hDEAD_BEEF, 4'hF});
    end
  endtask

  task automatic test_aw_delay();
    logic [67:0] got, exp;
    bit ok;
    int d0;
    d0 = done_count;
    aw_lat = 3;
    run_store(32'hA000_0040, 32'h1234_5678, 4'b0011);
    aw_lat = 0;
    checks++;
    if ({tr_wv[1], tr_wv[2]} !== 2'b10) begin
      errors++;
      $display("FAIL awd_wvalid: got %b want 10", {tr_wv[1], tr_wv[2]});
    end
    checks++;
    if ({tr_awv[1], tr_awv[2], tr_awv[3], tr_awv[4], tr_awv[5]} !== 5'b11110) begin
      errors++;
      $display("FAIL awd_awvalid: got %b want 11110", {tr_awv[1], tr_awv[2], tr_awv[3], tr_awv[4], tr_awv[5]});
    end
    checks++;
    if (tr_awaddr[1] !== 32'h0000_0040 || tr_awaddr[4] !== 32'h0000_0040) begin
      errors++;
      $display("FAIL awd_addr_stable: got %h/%h want 00000040", tr_awaddr[1], tr_awaddr[4]);
    end
    checks++;
    if ({tr_br[1], tr_br[2], tr_br[3], tr_br[4], tr_br[5]} !== 5'b00001) begin
      errors++;
      $display("FAIL awd_bready: got %b want 00001", {tr_br[1], tr_br[2], tr_br[3], tr_br[4], tr_br[5]});
    end
    checks++;
    if (done_cycle != 6 || done_count - d0 != 1) begin
      errors++;
      $display("FAIL awd_done: got cycle %0d count %0d want 6 and 1", done_cycle, done_count - d0);
    end
    sb_take(got, exp, ok);
    checks++;
    if (!ok || got !== exp) begin
      errors++;
      $display("FAIL awd_beat: got %h want %h", got, exp);
    end
  endtask

  task automatic test_w_delay_early_b();
    logic [67:0] got, exp;
    bit ok;
    int b0;
    b0 = b_count;
    w_lat = 5;
    b_early = 1'b1;
    run_store(32'h1234_5678, 32'hCAFE_F00D, 4'b1100);
    b_early = 1'b0;
    w_lat = 0;
    checks++;
    if ({tr_awv[1], tr_awv[2], tr_wv[6], tr_wv[7]} !== 4'b1010) begin
      errors++;
      $display("FAIL wd_valids: got %b want 1010", {tr_awv[1], tr_awv[2], tr_wv[6], tr_wv[7]});
    end
    checks++;
    if ({tr_br[1], tr_br[2], tr_br[3], tr_br[4], tr_br[5], tr_br[6], tr_br[7]} !== 7'b0000001) begin
      errors++;
      $display("FAIL wd_bready: got %b want 0000001",
               {tr_br[1], tr_br[2], tr_br[3], tr_br[4], tr_br[5], tr_br[6], tr_br[7]});
    end
    checks++;
    if (done_cycle != 8 || b_count - b0 != 1) begin
      errors++;
      $display("FAIL wd_b_once: got cycle %0d b %0d want 8 and 1", done_cycle, b_count - b0);
    end
    sb_take(got, exp, ok);
    checks++;
    if (!ok || got !== exp) begin
      errors++;
      $display("FAIL wd_beat: got %h want %h", got, exp);
    end
  endtask

  task automatic test_error_resp();
    logic [67:0] got, exp;
    bit ok;
    resp_val = 2'b10;
    run_store(32'hC000_0000, 32'h0BAD_0BAD, 4'b0001);
    checks++;
    if (mem_write_err !== 1'b1) begin
      errors++;
      $display("FAIL err_set: got %b want 1", mem_write_err);
    end
    resp_val = 2'b00;
    run_store(32'h9FFF_FFFC, 32'h0000_00AA, 4'b1000);
    checks++;
    if (tr_err[1] !== 1'b1 || mem_write_err !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky_clear: got %b then %b want 1 then 0", tr_err[1], mem_write_err);
    end
    for (int k = 0; k < 2; k++) begin
      sb_take(got, exp, ok);
      checks++;
      if (!ok || got !== exp) begin
        errors++;
        $display("FAIL err_beat%0d: got %h want %h", k, got, exp);
      end
    end
  endtask

  task automatic test_zero_sel();
    bit any_valid;
    int d0;
    d0 = done_count;
    run_store(32'h8000_0100, 32'h5555_5555, 4'b0000);
    any_valid = 1'b0;
    for (int i = 1; i < 64; i++) any_valid |= tr_awv[i] | tr_wv[i];
    checks++;
    if (any_valid || aw_obs.size() != 0 || w_obs.size() != 0) begin
      errors++;
      $display("FAIL sel0_no_bus: got valid %b aw %0d w %0d want none", any_valid, aw_obs.size(), w_obs.size());
    end
    checks++;
    if (done_cycle != 1 || {tr_busy[1], tr_busy[2]} !== 2'b10 || done_count - d0 != 1) begin
      errors++;
      $display("FAIL sel0_done: got cycle %0d busy %b count %0d want 1 10 1",
               done_cycle, {tr_busy[1], tr_busy[2]}, done_count - d0);
    end
  endtask

  task automatic test_back_to_back();
    logic [67:0] got, exp;
    bit ok;
    int c;
    int d0;
    d0 = done_count;
    @(negedge clk);
    mem_addr = 32'h8000_2000; mem_data = 32'h1111_2222; mem_sel = 4'hF; mem_we = 1'b1;
    exp_q.push_back({32'h0000_2000, 32'h1111_2222, 4'hF});
    c = 0;
    while (!mem_write_done && c < 20) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c != 3) begin
      errors++;
      $display("FAIL b2b_first_done: got cycle %0d want 3", c);
    end
    mem_addr = 32'h0000_3000; mem_data = 32'h3333_4444; mem_sel = 4'b0110;
    exp_q.push_back({32'h0000_3000, 32'h3333_4444, 4'b0110});
    @(negedge clk);
    checks++;
    if ({awvalid, write_busy} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_gap: got %b want 00", {awvalid, write_busy});
    end
    @(negedge clk);
    checks++;
    if (awvalid !== 1'b1 || awaddr !== 32'h0000_3000) begin
      errors++;
      $display("FAIL b2b_second_accept: got %b %h want 1 00003000", awvalid, awaddr);
    end
    c = 0;
    while (!mem_write_done && c < 20) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    mem_we = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (done_count - d0 != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d dones want 2", done_count - d0);
    end
    for (int k = 0; k < 2; k++) begin
      sb_take(got, exp, ok);
      checks++;
      if (!ok || got !== exp) begin
        errors++;
        $display("FAIL b2b_beat%0d: got %h want %h", k, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [67:0] got, exp;
    bit ok;
    aw_lat = 100;
    w_lat = 100;
    @(negedge clk);
    mem_addr = 32'h8000_4000; mem_data = 32'h7777_8888; mem_sel = 4'hF; mem_we = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({awvalid, wvalid, write_busy} !== 3'b111) begin
      errors++;
      $display("FAIL rst_mid_pre: got %b want 111", {awvalid, wvalid, write_busy});
    end
    reset = 1'b0;
    mem_we = 1'b0;
    #1;
    checks++;
    if ({awvalid, wvalid, write_busy} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_drop: got %b want 000", {awvalid, wvalid, write_busy});
    end
    @(negedge clk);
    reset = 1'b1;
    aw_lat = 0;
    w_lat = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({awvalid, wvalid, write_busy} !== 3'b000 || aw_obs.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_after: got %b aw %0d want 000 0", {awvalid, wvalid, write_busy}, aw_obs.size());
    end
    run_store(32'h0000_5000, 32'h9999_AAAA, 4'b0101);
    sb_take(got, exp, ok);
    checks++;
    if (!ok || got !== exp) begin
      errors++;
      $display("FAIL rst_mid_recover: got %h want %h", got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_aw_delay();
    test_w_delay_early_b();
    test_error_resp();
    test_zero_sel();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0 || aw_obs.size() != 0 || w_obs.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got exp %0d aw %0d w %0d want 0", exp_q.size(), aw_obs.size(), w_obs.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
